lift_step: RTL and testbench

LIFT_STEP -- requirements
Module: lift_step

---
 rtl/lift_pkg.sv | 18 +
 rtl/lift_step_core.sv | 65 ++++++
 rtl/lift_step.sv | 51 +++++
 tb/tb_lift_step.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/lift_pkg.sv
// Shared constants for the lifting-step datapath: operation codes and default sample width.
package lift_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [3:0] {
        INV_UPDATE  = 4'd4,
        FWD_UPDATE  = 4'd5,
        INV_PREDICT = 4'd6,
        FWD_PREDICT = 4'd7
    } lift_op_e;

    // Only codes 4..7 select a lifting operation; bit 3 set is always invalid.
    function automatic logic is_valid_op(input logic [3:0] flags);
        return (flags[3:2] == 2'b01);
    endfunction

endpackage

// File: rtl/lift_step_core.sv
// Combinational lifting arithmetic and narrowing to DATA_W+1 bits.
// Define LIFT_STEP_SAT_EN to saturate instead of wrapping on narrowing.
module lift_step_core
    import lift_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     update_i,
    input  logic [3:0]               flags_i,
    input  logic [DATA_W-1:0]        left_i,
    input  logic [DATA_W-1:0]        sam_i,
    input  logic [DATA_W-1:0]        right_i,
    output logic signed [DATA_W:0]   res_o,
    output logic                     vld_o
);

    localparam int EW = DATA_W + 3;
    localparam logic signed [EW-1:0] RND = EW'(2);

    logic signed [EW-1:0] w_l;
    logic signed [EW-1:0] w_s;
    logic signed [EW-1:0] w_r;
    logic signed [EW-1:0] w_pred;
    logic signed [EW-1:0] w_upd;
    logic signed [EW-1:0] w_full;

    function automatic logic signed [DATA_W:0] narrow(input logic signed [EW-1:0] x);
`ifdef LIFT_STEP_SAT_EN
        logic signed [EW-1:0] sat_max;
        logic signed [EW-1:0] sat_min;
        sat_max = EW'((2 ** DATA_W) - 1);
        sat_min = -sat_max - EW'(1);
        if (x > sat_max)
            return sat_max[DATA_W:0];
        else if (x < sat_min)
            return sat_min[DATA_W:0];
        else
            return x[DATA_W:0];
`else
        return x[DATA_W:0];
`endif
    endfunction

    // Three guard bits keep S +/- (L+R+2) and the neighbour half-sums free of overflow.
    assign w_l    = $signed({3'b000, left_i});
    assign w_s    = $signed({3'b000, sam_i});
    assign w_r    = $signed({3'b000, right_i});
    assign w_pred = (w_l >>> 1) + (w_r >>> 1);
    assign w_upd  = (w_l + w_r + RND) >>> 2;

    always_comb begin
        w_full = w_s;
        case (lift_op_e'(flags_i))
            FWD_PREDICT: w_full = w_s - w_pred;
            FWD_UPDATE:  w_full = w_s + w_upd;
            INV_PREDICT: w_full = w_s + w_pred;
            INV_UPDATE:  w_full = w_s - w_upd;
            default:     w_full = w_s;
        endcase
    end

    assign res_o = narrow(w_full);
    assign vld_o = update_i && is_valid_op(flags_i);

endmodule

// File: rtl/lift_step.sv
// Lifting step: registers the core result and the valid strobe (latency 1, no busy state).
// Optional macro LIFT_STEP_SAT_EN selects saturating narrowing in lift_step_core.
module lift_step
    import lift_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [3:0]               flags_i,
    input  logic                     update_i,
    input  logic [DATA_W-1:0]        left_i,
    input  logic [DATA_W-1:0]        sam_i,
    input  logic [DATA_W-1:0]        right_i,
    output logic signed [DATA_W:0]   res_o,
    output logic                     update_o
);

    logic signed [DATA_W:0] w_res_p0;
    logic                   w_vld_p0;
    logic signed [DATA_W:0] r_res_p1;
    logic                   r_vld_p1;

    lift_step_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .update_i (update_i),
        .flags_i  (flags_i),
        .left_i   (left_i),
        .sam_i    (sam_i),
        .right_i  (right_i),
        .res_o    (w_res_p0),
        .vld_o    (w_vld_p0)
    );

    // p0 -> p1: result only loads on a valid request, otherwise it holds.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_res_p1 <= '0;
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= w_vld_p0;
            if (w_vld_p0)
                r_res_p1 <= w_res_p0;
        end
    end

    assign res_o    = r_res_p1;
    assign update_o = r_vld_p1;

endmodule

// File: tb/tb_lift_step.sv
// Directed bench for lift_step: stimulus pushes expected responses, a monitor pops and compares.
module tb_lift_step;

    logic              clk_i = 1'b0;
    logic              rst_n_i = 1'b0;
    logic [3:0]        flags_i = 4'd0;
    logic              update_i = 1'b0;
    logic [7:0]        left_i = 8'd0;
    logic [7:0]        sam_i = 8'd0;
    logic [7:0]        right_i = 8'd0;
    logic signed [8:0] res_o;
    logic              update_o;

    typedef struct {
        logic              vld;
        logic signed [8:0] res;
        string             name;
    } exp_t;

    exp_t              sb[$];
    int                tests = 0;
    int                fails = 0;
    logic signed [8:0] last_res = 9'sd0;
    logic [9:0]        wide_sam;

`ifdef LIFT_STEP_SAT_EN
    localparam logic signed [8:0] EXP_FU_OVF  = 9'sd255;
    localparam logic signed [8:0] EXP_IP_OVF  = 9'sd255;
    localparam logic signed [8:0] EXP_FU_MAX  = 9'sd255;
    localparam logic signed [8:0] EXP_IP_MAX  = 9'sd255;
`else
    localparam logic signed [8:0] EXP_FU_OVF  = -9'sd181;
    localparam logic signed [8:0] EXP_IP_OVF  = -9'sd100;
    localparam logic signed [8:0] EXP_FU_MAX  = -9'sd129;
    localparam logic signed [8:0] EXP_IP_MAX  = -9'sd3;
`endif

    lift_step #(.DATA_W(8)) dut (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .flags_i  (flags_i),
        .update_i (update_i),
        .left_i   (left_i),
        .sam_i    (sam_i),
        .right_i  (right_i),
        .res_o    (res_o),
        .update_o (update_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic drive(input bit rel, input string nm, input logic upd, input logic [3:0] f,
                         input logic [7:0] l, input logic [7:0] s, input logic [7:0] r,
                         input logic ev, input logic signed [8:0] er);
        exp_t e;
        @(negedge clk_i);
        if (rel) rst_n_i = 1'b1;
        update_i = upd;
        flags_i  = f;
        left_i   = l;
        sam_i    = s;
        right_i  = r;
        if (ev) last_res = er;
        e.vld  = ev;
        e.res  = last_res;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic check_now(input string nm, input logic signed [8:0] er, input logic ev);
        tests++;
        if (res_o !== er || update_o !== ev) begin
            fails++;
            $display("FAIL %s: res_o=%0d update_o=%0b, required res_o=%0d update_o=%0b",
                     nm, res_o, update_o, er, ev);
        end
    endtask

    // Monitor: one expected entry per driven cycle, sampled after the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #2;
            if (rst_n_i) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    tests++;
                    if (res_o !== e.res || update_o !== e.vld) begin
                        fails++;
                        $display("FAIL %s: res_o=%0d update_o=%0b, required res_o=%0d update_o=%0b",
                                 e.name, res_o, update_o, e.res, e.vld);
                    end
                end else if (update_o !== 1'b0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_strobe: update_o=%0b, required 0", update_o);
                end
            end
        end
    end

    initial begin
        #3;
        check_now("reset_state", 9'sd0, 1'b0);

        // Request on the same edge reset is released.
        drive(1, "fwd_predict",      1, 4'd7, 8'd68,  8'd218, 8'd163, 1, 9'sd103);
        drive(0, "fwd_update_ovf",   1, 4'd5, 8'd164, 8'd250, 8'd160, 1, EXP_FU_OVF);
        drive(0, "inv_predict_ovf",  1, 4'd6, 8'd164, 8'd250, 8'd160, 1, EXP_IP_OVF);
        drive(0, "inv_predict",      1, 4'd6, 8'd10,  8'd5,   8'd20,  1, 9'sd20);
        wide_sam = 10'd459;
        drive(0, "inv_update_trunc", 1, 4'd4, 8'd164, wide_sam[7:0], 8'd160, 1, 9'sd122);
        drive(0, "invalid_flag3",    1, 4'd3, 8'd1,   8'd2,   8'd3,   0, 9'sd0);
        drive(0, "invalid_flag15",   1, 4'd15, 8'd200, 8'd9,  8'd77,  0, 9'sd0);
        drive(0, "idle_inputs_move", 0, 4'd7, 8'd255, 8'd0,  8'd255, 0, 9'sd0);
        drive(0, "fwd_predict_neg",  1, 4'd7, 8'd255, 8'd0,  8'd255, 1, -9'sd254);
        drive(0, "inv_update_neg",   1, 4'd4, 8'd255, 8'd0,  8'd255, 1, -9'sd128);
        drive(0, "fwd_update_max",   1, 4'd5, 8'd255, 8'd255, 8'd255, 1, EXP_FU_MAX);
        drive(0, "inv_predict_max",  1, 4'd6, 8'd255, 8'd255, 8'd255, 1, EXP_IP_MAX);
        drive(0, "fwd_predict_odd",  1, 4'd7, 8'd3,   8'd10,  8'd5,   1, 9'sd7);
        drive(0, "idle",             0, 4'd0, 8'd0,   8'd0,   8'd0,   0, 9'sd0);
        drive(0, "fwd_update_pre",   1, 4'd5, 8'd100, 8'd50,  8'd60,  1, 9'sd90);

        // Asynchronous reset mid-stream, after the strobe for the last request is visible.
        @(posedge clk_i);
        #3;
        rst_n_i = 1'b0;
        #1;
        check_now("reset_async", 9'sd0, 1'b0);
        @(posedge clk_i);
        #1;
        check_now("reset_held", 9'sd0, 1'b0);
        last_res = 9'sd0;
        drive(1, "after_release",    1, 4'd4, 8'd8,   8'd100, 8'd9,   1, 9'sd96);
        drive(0, "idle_end",         0, 4'd0, 8'd0,   8'd0,   8'd0,   0, 9'sd0);
        drive(0, "idle_end2",        0, 4'd6, 8'd50,  8'd50,  8'd50,  0, 9'sd0);

        repeat (3) @(posedge clk_i);
        #3;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries pending, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
